// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// Sel encodings, FSM states and the default watchdog limit.
package pipe_pkg;

    typedef enum logic [1:0] {
        SEL_LOAD = 2'b00,
        SEL_HOLD = 2'b01,
        SEL_CLR  = 2'b11
    } sel_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_e;

    localparam int unsigned MC_TIMEOUT_DEF = 255;

    typedef struct packed {
        logic pc_en;
        sel_e if_id;
        sel_e id_ex;
        sel_e ex_mem;
        sel_e mem_wb;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(
        input logic pc,
        input sel_e a,
        input sel_e b,
        input sel_e c,
        input sel_e d
    );
        ctrl_t r;
        r.pc_en  = pc;
        r.if_id  = a;
        r.id_ex  = b;
        r.ex_mem = c;
        r.mem_wb = d;
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones once reached.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubbles and flushes for a 5-stage pipe.
// Multi-cycle EX ops are tracked by a two-state FSM guarded by a watchdog.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEF,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             mem_busy_i,
    input  logic             ex_mc_i,
    input  logic             ex_mc_done_i,
    input  logic             ex_br_taken_i,
    input  logic             ex_memrd_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    output logic             pc_en_o,
    output logic [1:0]       if_id_sel_o,
    output logic [1:0]       id_ex_sel_o,
    output logic [1:0]       ex_mem_sel_o,
    output logic [1:0]       mem_wb_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mc_timeout_o
);

    localparam int WAIT_W = (MC_TIMEOUT < 2) ? 1 : $clog2(MC_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              to_q;
    logic              to_d;

    logic  in_wait;
    logic  wait_last;
    logic  mc_stall;
    logic  load_use;
    logic  rs1_hit;
    logic  rs2_hit;
    logic  ev_flush;
    logic  ev_busy;
    logic  ev_mc;
    logic  ev_br;
    logic  ev_lu;
    logic  fire;
    ctrl_t ctrl;
    ctrl_t ctrl_out;

    assign in_wait   = (state_q == ST_MC_WAIT);
    assign wait_last = (wait_q == WAIT_LAST);

    // Once in MC_WAIT only done or the watchdog ends the stall.
    assign mc_stall = in_wait ? (!ex_mc_done_i && !wait_last)
                              : (ex_mc_i && !ex_mc_done_i);

    assign rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use = ex_memrd_i && (ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);

    // One-hot events after priority masking.
    assign ev_flush = flush_i;
    assign ev_busy  = !flush_i && mem_busy_i;
    assign ev_mc    = !flush_i && !mem_busy_i && mc_stall;
    assign ev_br    = !flush_i && !mem_busy_i && !mc_stall && ex_br_taken_i;
    assign ev_lu    = !flush_i && !mem_busy_i && !mc_stall && !ex_br_taken_i
                      && load_use;

    assign fire = !flush_i && !mem_busy_i && in_wait
                  && !ex_mc_done_i && wait_last;

    always_comb begin
        ctrl = mk_ctrl(1'b1, SEL_LOAD, SEL_LOAD, SEL_LOAD, SEL_LOAD);
        unique case (1'b1)
            ev_flush: ctrl = mk_ctrl(1'b1, SEL_CLR, SEL_CLR, SEL_CLR, SEL_CLR);
            ev_busy:  ctrl = mk_ctrl(1'b0, SEL_HOLD, SEL_HOLD, SEL_HOLD, SEL_CLR);
            ev_mc:    ctrl = mk_ctrl(1'b0, SEL_HOLD, SEL_HOLD, SEL_CLR, SEL_LOAD);
            ev_br:    ctrl = mk_ctrl(1'b1, SEL_CLR, SEL_CLR, SEL_LOAD, SEL_LOAD);
            ev_lu:    ctrl = mk_ctrl(1'b0, SEL_HOLD, SEL_CLR, SEL_LOAD, SEL_LOAD);
            default:  ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        to_d    = to_q || fire;
        unique case (1'b1)
            ev_flush: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
            ev_busy: ;
            ev_mc: begin
                state_d = ST_MC_WAIT;
                wait_d  = in_wait ? (wait_q + 1'b1) : '0;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
        end
    end

    // Reset forces a frozen, cleared pipe regardless of inputs.
    assign ctrl_out = rst_ni ? ctrl
                             : mk_ctrl(1'b0, SEL_CLR, SEL_CLR, SEL_CLR, SEL_CLR);

    assign pc_en_o      = ctrl_out.pc_en;
    assign if_id_sel_o  = ctrl_out.if_id;
    assign id_ex_sel_o  = ctrl_out.id_ex;
    assign ex_mem_sel_o = ctrl_out.ex_mem;
    assign mem_wb_sel_o = ctrl_out.mem_wb;
    assign mc_timeout_o = to_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (!ctrl.pc_en),
        .cnt_o  (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (1'b0),
        .inc_i  (ev_flush || ev_br),
        .cnt_o  (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against an event-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int T    = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [1:0] L = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] C = 2'b11;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          mem_busy_i = 1'b0;
    logic          ex_mc_i = 1'b0;
    logic          ex_mc_done_i = 1'b0;
    logic          ex_br_taken_i = 1'b0;
    logic          ex_memrd_i = 1'b0;
    logic [4:0]    ex_rd_i = '0;
    logic [4:0]    id_rs1_i = '0;
    logic [4:0]    id_rs2_i = '0;
    logic          id_use_rs1_i = 1'b0;
    logic          id_use_rs2_i = 1'b0;
    logic          pc_en_o;
    logic [1:0]    if_id_sel_o;
    logic [1:0]    id_ex_sel_o;
    logic [1:0]    ex_mem_sel_o;
    logic [1:0]    mem_wb_sel_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;
    logic          mc_timeout_o;

    int total = 0;
    int bad = 0;

    // Reference model state: in a multi-cycle wait and how many wait cycles done.
    bit m_waiting;
    int m_waited;
    bit m_to;
    int m_stall;
    int m_flush;

    pipe_hazard_ctrl #(.MC_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .mem_busy_i   (mem_busy_i),
        .ex_mc_i      (ex_mc_i),
        .ex_mc_done_i (ex_mc_done_i),
        .ex_br_taken_i(ex_br_taken_i),
        .ex_memrd_i   (ex_memrd_i),
        .ex_rd_i      (ex_rd_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .pc_en_o      (pc_en_o),
        .if_id_sel_o  (if_id_sel_o),
        .id_ex_sel_o  (id_ex_sel_o),
        .ex_mem_sel_o (ex_mem_sel_o),
        .mem_wb_sel_o (mem_wb_sel_o),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o),
        .mc_timeout_o (mc_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {pc_en_o, if_id_sel_o, id_ex_sel_o, ex_mem_sel_o, mem_wb_sel_o};
    endfunction

    task automatic model_reset();
        m_waiting = 0;
        m_waited  = 0;
        m_to      = 0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic set_in(input bit fl, input bit bz, input bit mc, input bit dn,
                          input bit br, input bit mr, input int rd,
                          input int r1, input int r2, input bit u1, input bit u2);
        flush_i       = fl;
        mem_busy_i    = bz;
        ex_mc_i       = mc;
        ex_mc_done_i  = dn;
        ex_br_taken_i = br;
        ex_memrd_i    = mr;
        ex_rd_i       = 5'(rd);
        id_rs1_i      = 5'(r1);
        id_rs2_i      = 5'(r2);
        id_use_rs1_i  = u1;
        id_use_rs2_i  = u2;
    endtask

    // One clock: check outputs against the model, clock, then check counters.
    task automatic step(input string tag);
        logic [8:0] exp;
        bit lu;
        bit nw;
        int nc;
        bit cnt_fl;
        nw = m_waiting;
        nc = m_waited;
        cnt_fl = 0;
        lu = ex_memrd_i && (ex_rd_i != 0) &&
             ((id_use_rs1_i && id_rs1_i == ex_rd_i) ||
              (id_use_rs2_i && id_rs2_i == ex_rd_i));
        #2;
        if (flush_i) begin
            exp = {1'b1, C, C, C, C};
            nw = 0;
            cnt_fl = 1;
        end else if (mem_busy_i) begin
            exp = {1'b0, H, H, H, C};
        end else if (m_waiting ? (!ex_mc_done_i && m_waited + 1 < T)
                               : (ex_mc_i && !ex_mc_done_i)) begin
            exp = {1'b0, H, H, C, L};
            nc = m_waiting ? m_waited + 1 : 0;
            nw = 1;
        end else begin
            if (m_waiting && !ex_mc_done_i) m_to = 1;
            nw = 0;
            if (ex_br_taken_i) begin
                exp = {1'b1, C, C, L, L};
                cnt_fl = 1;
            end else if (lu) begin
                exp = {1'b0, H, C, L, L};
            end else begin
                exp = {1'b1, L, L, L, L};
            end
        end
        chk({tag, ".outs"}, 32'(outs()), 32'(exp));
        if (!exp[8] && m_stall < CMAX) m_stall++;
        if (cnt_fl && m_flush < CMAX) m_flush++;
        m_waiting = nw;
        m_waited = nc;
        @(posedge clk_i);
        #1;
        chk({tag, ".stall"}, 32'(stall_cnt_o), 32'(m_stall));
        chk({tag, ".flush"}, 32'(flush_cnt_o), 32'(m_flush));
        chk({tag, ".to"}, 32'(mc_timeout_o), 32'(m_to));
    endtask

    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        #2;
        chk({tag, ".rst_outs"}, 32'(outs()), 32'({1'b0, C, C, C, C}));
        chk({tag, ".rst_stall"}, 32'(stall_cnt_o), 32'd0);
        chk({tag, ".rst_flush"}, 32'(flush_cnt_o), 32'd0);
        chk({tag, ".rst_to"}, 32'(mc_timeout_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        idle();
        @(posedge clk_i);
        #1;
        do_reset("init");

        // Load-use on rs2, then clean advance.
        set_in(0, 0, 0, 0, 0, 1, 5, 1, 5, 0, 1);
        step("lu");
        chk("lu.cnt1", 32'(stall_cnt_o), 32'd1);
        idle();
        step("lu_next");

        // Load into x0 never stalls.
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        step("rd0");

        // Multi-cycle op done on the 4th cycle.
        do_reset("mc_pre");
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, i == 3, 0, 0, 0, 0, 0, 0, 0);
            step($sformatf("mc%0d", i));
        end
        chk("mc.cnt3", 32'(stall_cnt_o), 32'd3);
        idle();
        step("mc_after");

        // Branch masked by mem_busy for two cycles.
        do_reset("br_pre");
        for (int i = 0; i < 3; i++) begin
            set_in(0, i < 2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
            step($sformatf("brbz%0d", i));
        end
        chk("brbz.fl1", 32'(flush_cnt_o), 32'd1);

        // Watchdog: done never arrives.
        do_reset("to_pre");
        for (int i = 0; i < T + 1; i++) begin
            set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            step($sformatf("to%0d", i));
        end
        chk("to.sticky", 32'(mc_timeout_o), 32'd1);
        idle();
        for (int i = 0; i < 3; i++) step("to_idle");
        chk("to.still", 32'(mc_timeout_o), 32'd1);

        // Reset while waiting on a multi-cycle op.
        do_reset("mw_pre");
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("mw0");
        step("mw1");
        #1;
        do_reset("mw_rst");
        idle();
        step("mw_after");

        // Flush during a wait.
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("fw0");
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("fw1");

        // Random traffic; small counters reach saturation.
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(0, 19) == 0,
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 5) == 0,
                   $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3),
                   $urandom_range(0, 3),
                   $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1);
            step("rnd");
        end
        chk("sat.stall", 32'(stall_cnt_o), 32'(CMAX));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
